// File: rtl/mul_seq_16.sv
// Sequential radix-2 shift-and-add unsigned multiplier (WIDTH x WIDTH -> 2*WIDTH).
// The adder is external: operands go out on add_in*, sum/carry come back the same cycle.
module mul_seq_16 #(
  parameter int WIDTH = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   op_a,
  input  logic [WIDTH-1:0]   op_b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product,
  output logic [WIDTH-1:0]   add_in1,
  output logic [WIDTH-1:0]   add_in2,
  output logic               add_cin,
  input  logic [WIDTH-1:0]   add_sum,
  input  logic               add_cout
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] mcand, acc_hi, mq;
  logic [CW-1:0]    cnt;
  logic             last;

  assign last    = (cnt == CW'(WIDTH - 1));
  assign add_cin = 1'b0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    busy    = 1'b0;
    done    = 1'b0;
    add_in1 = '0;
    add_in2 = '0;
    case (state_q)
      IDLE: if (start) state_d = CALC;
      CALC: begin
        busy    = 1'b1;
        add_in1 = acc_hi;
        add_in2 = mq[0] ? mcand : '0;
        if (last) state_d = DONE;
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Each CALC cycle adds the gated multiplicand into the high half, then shifts
  // {carry, sum, mq} right by one; the sum LSB becomes the next product bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand   <= '0;
      acc_hi  <= '0;
      mq      <= '0;
      cnt     <= '0;
      product <= '0;
    end else begin
      case (state_q)
        IDLE: if (start) begin
          mcand  <= op_a;
          mq     <= op_b;
          acc_hi <= '0;
          cnt    <= '0;
        end
        CALC: begin
          acc_hi <= {add_cout, add_sum[WIDTH-1:1]};
          mq     <= {add_sum[0], mq[WIDTH-1:1]};
          cnt    <= cnt + CW'(1);
          if (last) product <= {add_cout, add_sum, mq[WIDTH-1:1]};
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mul_seq_16.sv
// Bench for mul_seq_16: behavioural adder, cycle-age timing model with a
// per-cycle compare, plus directed operations with literal expected products.
module tb_mul_seq_16;
  localparam int W = 16;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           start;
  logic [W-1:0]   op_a, op_b;
  logic           busy, done, add_cin, add_cout;
  logic [2*W-1:0] product;
  logic [W-1:0]   add_in1, add_in2, add_sum;

  always #5 clk = ~clk;

  // Stand-in for the external 16-bit full adder.
  assign {add_cout, add_sum} = {1'b0, add_in1} + {1'b0, add_in2} + {16'd0, add_cin};

  mul_seq_16 #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op_a(op_a), .op_b(op_b),
    .busy(busy), .done(done), .product(product),
    .add_in1(add_in1), .add_in2(add_in2), .add_cin(add_cin),
    .add_sum(add_sum), .add_cout(add_cout)
  );

  // Model: m_age = cycles since acceptance (-1 when idle). Busy for ages 1..W,
  // done at age W+1, product loaded on entering age W+1.
  int             m_age;
  logic [2*W-1:0] m_pend, m_prod;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_age  <= -1;
      m_pend <= '0;
      m_prod <= '0;
    end else if (m_age < 0) begin
      if (start) begin
        m_pend <= 32'(op_a) * 32'(op_b);
        m_age  <= 1;
      end
    end else if (m_age == W + 1) begin
      m_age <= -1;
    end else begin
      m_age <= m_age + 1;
      if (m_age == W) m_prod <= m_pend;
    end
  end

  int checks = 0, errors = 0, done_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [31:0] exp, input string name);
    int n;
    bit seen;
    @(posedge clk); #1;
    start = 1'b1; op_a = a; op_b = b;
    @(posedge clk); #1;
    start = 1'b0; op_a = W'($urandom); op_b = W'($urandom);
    seen = 0;
    n = 0;
    for (int i = 1; i <= 40 && !seen; i++) begin
      @(negedge clk);
      if (done) begin seen = 1; n = i; end
    end
    if (!seen) chk({name, "_timeout"}, 32'd0, 32'd1);
    else begin
      chk({name, "_latency"}, 32'(n), 32'(W + 1));
      chk({name, "_product"}, product, exp);
      chk({name, "_model"}, m_prod, exp);
    end
  endtask

  initial begin
    int d0;
    rst_n = 1'b0; start = 1'b0; op_a = '0; op_b = '0;

    fork
      forever begin
        @(negedge clk);
        chk("busy", 32'(busy), 32'(m_age >= 1 && m_age <= W));
        chk("done", 32'(done), 32'(m_age == W + 1));
        chk("product", product, m_prod);
        chk("add_cin", 32'(add_cin), 32'd0);
        if (!busy) chk("add_idle", {add_in1, add_in2}, 32'd0);
        if (done) done_cnt++;
      end
    join_none

    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_product", product, 32'd0);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    run_op(16'd3,    16'd5,    32'd15,        "3x5");
    run_op(16'hFFFF, 16'hFFFF, 32'hFFFE0001, "ffff_sq");
    run_op(16'h8000, 16'h0002, 32'h00010000, "8000x2");
    run_op(16'h0000, 16'h1234, 32'h00000000, "0x1234");
    run_op(16'h1234, 16'h0001, 32'h00001234, "1234x1");

    // Start pulse mid-CALC with new operands must be ignored.
    d0 = done_cnt;
    @(posedge clk); #1;
    start = 1'b1; op_a = 16'h00FF; op_b = 16'h0101;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    start = 1'b1; op_a = 16'hAAAA; op_b = 16'h5555;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (16) @(posedge clk);
    #1;
    chk("midstart_product", product, 32'h0000FFFF);
    chk("midstart_single_done", 32'(done_cnt - d0), 32'd1);

    // Reset at CALC cycle 8 aborts with no done pulse.
    d0 = done_cnt;
    @(posedge clk); #1;
    start = 1'b1; op_a = 16'h1234; op_b = 16'h5678;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_product", product, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (20) @(posedge clk);
    chk("abort_no_done", 32'(done_cnt - d0), 32'd0);
    run_op(16'd7, 16'd9, 32'd63, "7x9");

    // Start held high: one acceptance every W+2 cycles, operands varying.
    d0 = done_cnt;
    @(posedge clk); #1;
    start = 1'b1; op_a = 16'd100; op_b = 16'd200;
    repeat (3 * (W + 2)) begin
      @(posedge clk); #1;
      op_a = W'($urandom); op_b = W'($urandom);
    end
    start = 1'b0;
    repeat (4) @(posedge clk);
    chk("b2b_done_count", 32'(done_cnt - d0), 32'd3);

    repeat (2) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1);
  end

endmodule
